// File: rtl/dual_branch_predictor_pkg.sv
// Shared parameters, counter encodings and BTB entry layout for the dual-issue branch predictor.
package dual_branch_predictor_pkg;

    localparam int BHT_ENTRIES = 64;
    localparam int INDEX_LSB   = 2;
    localparam int INDEX_MSB   = 7;
    localparam int TAG_LSB     = 8;
    localparam int INDEX_WIDTH = INDEX_MSB - INDEX_LSB + 1;
    localparam int TAG_WIDTH   = 32 - TAG_LSB;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } counterT;

    localparam counterT COUNTER_RESET = WEAK_NT;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
        logic [31:0]          target;
    } btbEntryT;

    function automatic logic tagHit(input btbEntryT entry, input logic [31:0] pc);
        return entry.valid && (entry.tag == pc[31:TAG_LSB]);
    endfunction

endpackage

// File: rtl/dual_branch_predictor_sat.sv
// Combinational 2-bit saturating counter next-state function.
module sat_counter2
    import dual_branch_predictor_pkg::*;
(
    input  counterT count,
    input  logic    taken,
    output counterT nextCount
);

    always_comb begin
        nextCount = count;
        if (taken && count != STRONG_T) begin
            nextCount = counterT'(count + 2'd1);
        end else if (!taken && count != STRONG_NT) begin
            nextCount = counterT'(count - 2'd1);
        end
    end

endmodule

// File: rtl/dual_branch_predictor.sv
// Two-slot branch predictor: 64-entry BHT of 2-bit counters plus a 64-entry BTB,
// combinational lookup in Fetch and in-order update from Execute.
module dual_branch_predictor
    import dual_branch_predictor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF1,
    input  logic [31:0] pcF2,
    output logic        predictionF1,
    output logic        predictionF2,
    output logic [31:0] targetF1,
    output logic [31:0] targetF2,
    input  logic        branchE1,
    input  logic        branchE2,
    input  logic        takenBranchE1,
    input  logic        takenBranchE2,
    input  logic        predictionE1,
    input  logic        predictionE2,
    input  logic [31:0] pcE1,
    input  logic [31:0] pcE2,
    input  logic [31:0] targetE1,
    input  logic [31:0] targetE2,
    output logic [31:0] mispredCount
);

    counterT  bht [BHT_ENTRIES];
    btbEntryT btb [BHT_ENTRIES];

    logic [INDEX_WIDTH-1:0] idxF1, idxF2, idxE1, idxE2;
    logic                   hitF1, hitF2;
    logic                   mispred1, mispred2, update2, sameIndex;
    btbEntryT               entry2, newEntry1, newEntry2;
    counterT                count1, count2, base2, next1, next2;
    logic [1:0]             mispredIncr;
    logic [32:0]            mispredSum;

    assign idxF1 = pcF1[INDEX_MSB:INDEX_LSB];
    assign idxF2 = pcF2[INDEX_MSB:INDEX_LSB];
    assign idxE1 = pcE1[INDEX_MSB:INDEX_LSB];
    assign idxE2 = pcE2[INDEX_MSB:INDEX_LSB];

    // Lookup reads the registered arrays, so a same-cycle update is not visible yet.
    always_comb begin
        hitF1        = tagHit(btb[idxF1], pcF1);
        hitF2        = tagHit(btb[idxF2], pcF2);
        predictionF1 = 1'b0;
        predictionF2 = 1'b0;
        targetF1     = '0;
        targetF2     = '0;
        if (!rst) begin
            predictionF1 = hitF1 && (bht[idxF1] >= WEAK_T);
            predictionF2 = hitF2 && (bht[idxF2] >= WEAK_T) && !predictionF1;
            targetF1     = hitF1 ? btb[idxF1].target : '0;
            targetF2     = hitF2 ? btb[idxF2].target : '0;
        end
    end

    // Slot 2 sees the entry as slot 1 leaves it; a miss restarts the counter from weak-NT.
    always_comb begin
        mispred1  = branchE1 && (predictionE1 ^ takenBranchE1);
        update2   = branchE2 && !mispred1;
        mispred2  = update2 && (predictionE2 ^ takenBranchE2);
        count1    = tagHit(btb[idxE1], pcE1) ? bht[idxE1] : COUNTER_RESET;
        newEntry1 = '{valid: 1'b1, tag: pcE1[31:TAG_LSB], target: targetE1};
        newEntry2 = '{valid: 1'b1, tag: pcE2[31:TAG_LSB], target: targetE2};
        sameIndex = branchE1 && (idxE1 == idxE2);
        entry2    = btb[idxE2];
        base2     = bht[idxE2];
        if (sameIndex) begin
            base2 = next1;
            if (takenBranchE1) begin
                entry2 = newEntry1;
            end
        end
        count2 = tagHit(entry2, pcE2) ? base2 : COUNTER_RESET;
    end

    sat_counter2 u_satSlot1 (.count(count1), .taken(takenBranchE1), .nextCount(next1));
    sat_counter2 u_satSlot2 (.count(count2), .taken(takenBranchE2), .nextCount(next2));

    assign mispredIncr = {1'b0, mispred1} + {1'b0, mispred2};
    assign mispredSum  = {1'b0, mispredCount} + {31'b0, mispredIncr};

    // NOTE: the tables are plain flops, not RAM, so every entry can be cleared in one reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= COUNTER_RESET;
                btb[i] <= '0;
            end
            mispredCount <= '0;
        end else begin
            if (branchE1) begin
                bht[idxE1] <= next1;
                if (takenBranchE1) begin
                    btb[idxE1] <= newEntry1;
                end
            end
            // Slot 2 is written last so that, on a shared index, its chained result wins.
            if (update2) begin
                bht[idxE2] <= next2;
                if (takenBranchE2) begin
                    btb[idxE2] <= newEntry2;
                end
            end
            mispredCount <= mispredSum[32] ? 32'hFFFF_FFFF : mispredSum[31:0];
        end
    end

endmodule

// File: tb/tb_dual_branch_predictor.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural table model.
module tb_dual_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcF1 = '0, pcF2 = '0;
    logic        predictionF1, predictionF2;
    logic [31:0] targetF1, targetF2;
    logic        branchE1 = 1'b0, branchE2 = 1'b0;
    logic        takenBranchE1 = 1'b0, takenBranchE2 = 1'b0;
    logic        predictionE1 = 1'b0, predictionE2 = 1'b0;
    logic [31:0] pcE1 = '0, pcE2 = '0, targetE1 = '0, targetE2 = '0;
    logic [31:0] mispredCount;

    always #5 clk = ~clk;

    dual_branch_predictor dut (
        .clk(clk), .rst(rst),
        .pcF1(pcF1), .pcF2(pcF2),
        .predictionF1(predictionF1), .predictionF2(predictionF2),
        .targetF1(targetF1), .targetF2(targetF2),
        .branchE1(branchE1), .branchE2(branchE2),
        .takenBranchE1(takenBranchE1), .takenBranchE2(takenBranchE2),
        .predictionE1(predictionE1), .predictionE2(predictionE2),
        .pcE1(pcE1), .pcE2(pcE2), .targetE1(targetE1), .targetE2(targetE2),
        .mispredCount(mispredCount)
    );

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: table contents as plain integers, updates applied in program order.
    int        modelCnt    [64];
    bit        modelValid  [64];
    bit [23:0] modelTag    [64];
    bit [31:0] modelTarget [64];
    longint    modelMis;

    function automatic void modelReset();
        for (int i = 0; i < 64; i++) begin
            modelCnt[i]    = 1;
            modelValid[i]  = 1'b0;
            modelTag[i]    = '0;
            modelTarget[i] = '0;
        end
        modelMis = 0;
    endfunction

    function automatic bit modelHit(input bit [31:0] pc);
        int i = int'(pc[7:2]);
        return modelValid[i] && (modelTag[i] == pc[31:8]);
    endfunction

    function automatic bit modelPredict(input bit [31:0] pc);
        return modelHit(pc) && (modelCnt[int'(pc[7:2])] >= 2);
    endfunction

    function automatic bit [31:0] modelTargetOf(input bit [31:0] pc);
        return modelHit(pc) ? modelTarget[int'(pc[7:2])] : 32'h0;
    endfunction

    function automatic void modelUpdate(input bit [31:0] pc, input bit taken, input bit [31:0] tgt);
        int i = int'(pc[7:2]);
        int c = modelHit(pc) ? modelCnt[i] : 1;
        c = taken ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
        modelCnt[i] = c;
        if (taken) begin
            modelValid[i]  = 1'b1;
            modelTag[i]    = pc[31:8];
            modelTarget[i] = tgt;
        end
    endfunction

    function automatic void modelStep();
        bit m1, m2;
        if (rst) begin
            modelReset();
            return;
        end
        m1 = branchE1 && (predictionE1 != takenBranchE1);
        m2 = branchE2 && !m1 && (predictionE2 != takenBranchE2);
        if (branchE1) modelUpdate(pcE1, takenBranchE1, targetE1);
        if (branchE2 && !m1) modelUpdate(pcE2, takenBranchE2, targetE2);
        modelMis = modelMis + int'(m1) + int'(m2);
        if (modelMis > 64'h0000_0000_FFFF_FFFF) modelMis = 64'h0000_0000_FFFF_FFFF;
    endfunction

    initial modelReset();

    bit        expP1, expP2;
    bit [31:0] expT1, expT2;

    // Outputs are compared mid-cycle, then the model advances with the inputs the next edge will see.
    always @(negedge clk) begin
        if (checkEn) begin
            expP1 = !rst && modelPredict(pcF1);
            expP2 = !rst && modelPredict(pcF2) && !expP1;
            expT1 = rst ? 32'h0 : modelTargetOf(pcF1);
            expT2 = rst ? 32'h0 : modelTargetOf(pcF2);
            check("predictionF1", predictionF1, expP1);
            check("predictionF2", predictionF2, expP2);
            check("targetF1", targetF1, expT1);
            check("targetF2", targetF2, expT2);
            check("mispredCount", mispredCount, modelMis[31:0]);
        end
        modelStep();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] randPc();
        bit [23:0] tags [3] = '{24'h004000, 24'h004010, 24'h123456};
        bit [5:0]  idxs [4] = '{6'd4, 6'd5, 6'd32, 6'd63};
        return {tags[$urandom_range(0, 2)], idxs[$urandom_range(0, 3)], 2'b00};
    endfunction

    bit predSeq [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bit expSeq  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    int cntSeq  [4] = '{2, 1, 0, 0};

    initial begin
        tick();
        tick();
        checkEn = 1'b1;
        rst = 1'b0;

        // Cold lookup misses.
        pcF1 = 32'h0040_0010;
        #1;
        check("cold predictionF1", predictionF1, 1'b0);
        check("cold targetF1", targetF1, 32'h0);

        // Two taken updates train the entry to strong-taken.
        branchE1 = 1'b1; takenBranchE1 = 1'b1; predictionE1 = 1'b0;
        pcE1 = 32'h0040_0010; targetE1 = 32'h0040_0040;
        tick();
        predictionE1 = 1'b1;
        tick();
        branchE1 = 1'b0;
        #1;
        check("trained predictionF1", predictionF1, 1'b1);
        check("trained targetF1", targetF1, 32'h0040_0040);
        check("model counter strong-T", modelCnt[4], 32'd3);

        // Not-taken walk down to strong-NT, then saturation.
        for (int k = 0; k < 4; k++) begin
            branchE1 = 1'b1; takenBranchE1 = 1'b0; predictionE1 = predSeq[k];
            tick();
            branchE1 = 1'b0;
            #1;
            check("walk predictionF1", predictionF1, expSeq[k]);
            check("walk model counter", modelCnt[4], cntSeq[k]);
        end
        check("mispredCount before flush", mispredCount, 32'd3);

        // Slot-1 mispredict flushes slot 2.
        branchE1 = 1'b1; predictionE1 = 1'b1; takenBranchE1 = 1'b0; pcE1 = 32'h0040_0010;
        branchE2 = 1'b1; predictionE2 = 1'b0; takenBranchE2 = 1'b1;
        pcE2 = 32'h0040_0080; targetE2 = 32'h0040_0200;
        tick();
        branchE1 = 1'b0; branchE2 = 1'b0;
        pcF1 = 32'h0040_0080;
        #1;
        check("flushed predictionF1", predictionF1, 1'b0);
        check("flushed targetF1", targetF1, 32'h0);
        check("flush mispredCount", mispredCount, 32'd4);
        check("flushed model counter", modelCnt[32], 32'd1);

        // Same index, different tags, both taken: slot 2 replaces slot 1's entry.
        branchE1 = 1'b1; predictionE1 = 1'b1; takenBranchE1 = 1'b1;
        pcE1 = 32'h0040_0010; targetE1 = 32'h0040_0040;
        branchE2 = 1'b1; predictionE2 = 1'b1; takenBranchE2 = 1'b1;
        pcE2 = 32'h0040_1010; targetE2 = 32'h0040_1100;
        tick();
        branchE1 = 1'b0; branchE2 = 1'b0;
        pcF1 = 32'h0040_1010; pcF2 = 32'h0040_0010;
        #1;
        check("alias predictionF1", predictionF1, 1'b1);
        check("alias targetF1", targetF1, 32'h0040_1100);
        check("alias predictionF2", predictionF2, 1'b0);
        check("alias targetF2", targetF2, 32'h0);
        check("alias model counter", modelCnt[4], 32'd2);
        check("alias model tag", modelTag[4], 32'h0000_4010);
        check("alias mispredCount", mispredCount, 32'd4);

        // Reset coinciding with an update discards it.
        rst = 1'b1;
        branchE1 = 1'b1; takenBranchE1 = 1'b1; predictionE1 = 1'b0;
        pcE1 = 32'h0040_0080; targetE1 = 32'h0000_1234;
        #1;
        check("reset-cycle predictionF1", predictionF1, 1'b0);
        check("reset-cycle targetF1", targetF1, 32'h0);
        tick();
        rst = 1'b0; branchE1 = 1'b0;
        pcF2 = 32'h0040_0080;
        #1;
        check("post-reset predictionF1", predictionF1, 1'b0);
        check("post-reset predictionF2", predictionF2, 1'b0);
        check("post-reset targetF2", targetF2, 32'h0);
        check("post-reset mispredCount", mispredCount, 32'd0);

        // Randomized traffic on a small PC pool so hits, aliases and flushes are frequent.
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 59) == 0);
            pcF1          = randPc();
            pcF2          = randPc();
            branchE1      = 1'($urandom_range(0, 1));
            takenBranchE1 = 1'($urandom_range(0, 1));
            predictionE1  = ($urandom_range(0, 3) != 0) ? takenBranchE1 : !takenBranchE1;
            pcE1          = randPc();
            targetE1      = $urandom;
            branchE2      = 1'($urandom_range(0, 1));
            takenBranchE2 = 1'($urandom_range(0, 1));
            predictionE2  = ($urandom_range(0, 3) != 0) ? takenBranchE2 : !takenBranchE2;
            pcE2          = ($urandom_range(0, 2) == 0) ? {randPc()[31:8], pcE1[7:0]} : randPc();
            targetE2      = $urandom;
            tick();
        end

        rst = 1'b0; branchE1 = 1'b0; branchE2 = 1'b0;
        tick();
        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
